// File: rtl/hilo_muldiv_pkg.sv
// Shared constants for the HI/LO multiply-divide unit: operation codes and FSM state encodings.
package hilo_muldiv_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_FIX  = 2'd3;

endpackage

// File: rtl/hilo_muldiv.sv
// Iterative HI/LO multiply/divide unit: radix-2 shift-add multiply, restoring divide,
// fixed 33-cycle latency with sign correction applied in a final FIX cycle.
module hilo_muldiv
  import hilo_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_data,
  output logic [WIDTH-1:0] lo_data
);

  localparam int CW = $clog2(WIDTH);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mq_q, mq_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             neg_lo_q, neg_lo_d;
  logic             neg_hi_q, neg_hi_d;
  logic             is_div_q, is_div_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             signed_op, sa, sb;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   add_sel, rem_sh;
  logic [2*WIDTH-1:0] prod, prod_fix;

  always_comb begin
    signed_op = (op == OP_MULT) || (op == OP_DIV);
    sa        = signed_op & a[WIDTH-1];
    sb        = signed_op & b[WIDTH-1];
    abs_a     = sa ? -a : a;
    abs_b     = sb ? -b : b;
    add_sel   = mq_q[0] ? ({1'b0, acc_q} + {1'b0, opb_q}) : {1'b0, acc_q};
    rem_sh    = {acc_q, mq_q[WIDTH-1]};
    prod      = {acc_q, mq_q};
    prod_fix  = neg_lo_q ? -prod : prod;

    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mq_d     = mq_q;
    opb_d    = opb_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    is_div_d = is_div_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              state_d  = (op == OP_DIV || op == OP_DIVU) ? ST_DIV : ST_MUL;
              is_div_d = (op == OP_DIV || op == OP_DIVU);
              cnt_d    = '0;
              acc_d    = '0;
              mq_d     = abs_a;
              opb_d    = abs_b;
              // Divide-by-zero keeps the quotient all-ones, so only the remainder follows a's sign
              neg_lo_d = (sa ^ sb) & ((op == OP_MULT) | (b != '0));
              neg_hi_d = sa;
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      ST_MUL, ST_DIV: begin
        if (state_q == ST_MUL) begin
          acc_d = add_sel[WIDTH:1];
          mq_d  = {add_sel[0], mq_q[WIDTH-1:1]};
        end else if (rem_sh >= {1'b0, opb_q}) begin
          acc_d = WIDTH'(rem_sh - {1'b0, opb_q});
          mq_d  = {mq_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = rem_sh[WIDTH-1:0];
          mq_d  = {mq_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = ST_FIX;
        end
      end
      default: begin
        if (is_div_q) begin
          lo_d = neg_lo_q ? -mq_q : mq_q;
          hi_d = neg_hi_q ? -acc_q : acc_q;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_q == ST_FIX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mq_q     <= '0;
      opb_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      is_div_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mq_q     <= mq_d;
      opb_q    <= opb_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      is_div_q <= is_div_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign hi_data = hi_q;
  assign lo_data = lo_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed bench for hilo_muldiv: hand-computed vectors checked with immediate assertions.
module tb_hilo_muldiv;
  import hilo_muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        busy, done;
  logic [31:0] hi_data, lo_data;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_hi = 32'd0;
  logic [31:0] exp_lo = 32'd0;

  always #5 clk = ~clk;

  hilo_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi_data(hi_data), .lo_data(lo_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Issue one multiply/divide and follow it to completion; optionally inject an MTLO at sample inj_at.
  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] va,
                        input logic [31:0] vb, input logic [31:0] ehi, input logic [31:0] elo,
                        input int inj_at);
    int   done_j = -1;
    int   busy_n = 0;
    logic busy_at_done = 1'b1;
    @(negedge clk);
    start = 1'b1; op = o; a = va; b = vb;
    @(posedge clk);
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (j == 0) start = 1'b0;
      if (inj_at >= 0 && j == inj_at) begin
        start = 1'b1; op = OP_MTLO; a = 32'hDEAD_BEEF;
      end
      if (inj_at >= 0 && j == inj_at + 1) start = 1'b0;
      if (j == 5) begin
        check({name, "_hold_hi"}, hi_data, exp_hi);
        check({name, "_hold_lo"}, lo_data, exp_lo);
      end
      if (done) begin
        done_j = j;
        busy_at_done = busy;
        break;
      end
      if (busy) busy_n++;
    end
    start = 1'b0;
    check({name, "_latency"}, 32'(done_j), 32'd33);
    check({name, "_busy_cycles"}, 32'(busy_n), 32'd33);
    check({name, "_busy_at_done"}, {31'd0, busy_at_done}, 32'd0);
    check({name, "_hi"}, hi_data, ehi);
    check({name, "_lo"}, lo_data, elo);
    exp_hi = ehi;
    exp_lo = elo;
    $display("%s a=%h b=%h -> hi=%h lo=%h done_at=%0d", name, va, vb, hi_data, lo_data, done_j);
    @(negedge clk);
    check({name, "_done_pulse_end"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int seen_done;

    @(negedge clk);
    check("reset_hi", hi_data, 32'd0);
    check("reset_lo", lo_data, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    $display("reset released");

    // MTHI then MTLO on consecutive edges
    start = 1'b1; op = OP_MTHI; a = 32'h1234_5678;
    @(negedge clk);
    check("mthi_hi", hi_data, 32'h1234_5678);
    check("mthi_lo", lo_data, 32'd0);
    check("mthi_busy", {31'd0, busy}, 32'd0);
    check("mthi_done", {31'd0, done}, 32'd0);
    op = OP_MTLO; a = 32'h9ABC_DEF0;
    @(negedge clk);
    start = 1'b0;
    check("mtlo_lo", lo_data, 32'h9ABC_DEF0);
    check("mtlo_hi", hi_data, 32'h1234_5678);
    check("mtlo_busy", {31'd0, busy}, 32'd0);
    check("mtlo_done", {31'd0, done}, 32'd0);
    exp_hi = 32'h1234_5678;
    exp_lo = 32'h9ABC_DEF0;
    $display("mthi/mtlo hi=%h lo=%h", hi_data, lo_data);

    run_op("mult_m3x7",   OP_MULT,  32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB, -1);
    run_op("multu_max",   OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, -1);
    run_op("div_m7d2",    OP_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, -1);
    run_op("divu_7d0",    OP_DIVU,  32'd7,         32'd0,        32'd7,         32'hFFFF_FFFF, -1);
    run_op("div_min_m1",  OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, -1);
    run_op("mult_minsq",  OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,        -1);
    run_op("div_m7dm2",   OP_DIV,   32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd3,        -1);
    run_op("div_m5d0",    OP_DIV,   32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 32'hFFFF_FFFF, -1);

    // Reserved op codes must not disturb anything
    @(negedge clk);
    start = 1'b1; op = 3'd6; a = 32'hFFFF_FFFF; b = 32'd1;
    @(negedge clk);
    op = 3'd7;
    @(negedge clk);
    start = 1'b0;
    check("rsvd_busy", {31'd0, busy}, 32'd0);
    check("rsvd_hi", hi_data, exp_hi);
    check("rsvd_lo", lo_data, exp_lo);
    $display("reserved ops 6,7 -> busy=%b hi=%h lo=%h", busy, hi_data, lo_data);

    run_op("divu_inj",    OP_DIVU,  32'd100,       32'd7,        32'd2,         32'd14,       10);

    // Reset in the middle of a MULT
    @(negedge clk);
    start = 1'b1; op = OP_MULT; a = 32'd1234; b = 32'd5678;
    @(posedge clk);
    for (int j = 0; j < 15; j++) begin
      @(negedge clk);
      if (j == 0) start = 1'b0;
    end
    check("abort_busy_before", {31'd0, busy}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check("abort_hi", hi_data, 32'd0);
    check("abort_lo", lo_data, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen_done = 0;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (done || busy) seen_done = 1;
    end
    check("abort_no_done", 32'(seen_done), 32'd0);
    check("abort_hi_after", hi_data, 32'd0);
    check("abort_lo_after", lo_data, 32'd0);
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    $display("reset mid-mult -> hi=%h lo=%h busy=%b", hi_data, lo_data, busy);

    run_op("multu_3x5",   OP_MULTU, 32'd3,         32'd5,        32'd0,         32'd15,       -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
